// File: rtl/video_pixel_mux_pkg.sv
// Shared constants, palette address type and mirroring helpers for the pixel mux.
package video_pixel_mux_pkg;

    localparam int PM_GREYSCALE = 0;
    localparam int PM_BG_CLIP   = 1;
    localparam int PM_SP_CLIP   = 2;
    localparam int PM_BG_EN     = 3;
    localparam int PM_SP_EN     = 4;
    localparam int PM_EMPH_LSB  = 5;
    localparam int PM_EMPH_MSB  = 7;

    typedef logic [4:0] pal_addr_t;

    localparam pal_addr_t  PAL_BACKDROP = 5'h00;
    localparam logic [5:0] GREY_MASK    = 6'h30;

    // CPU view: sprite backdrop slots 0x10/14/18/1C fold onto 0x00/04/08/0C.
    function automatic pal_addr_t pal_mirror(input pal_addr_t addr);
        pal_addr_t m;
        m = addr;
        if (addr[1:0] == 2'b00) begin
            m[4] = 1'b0;
        end
        return m;
    endfunction

    // Pixel view: every transparent-index slot shows the universal backdrop.
    function automatic pal_addr_t pix_mirror(input pal_addr_t addr);
        return (addr[1:0] == 2'b00) ? PAL_BACKDROP : addr;
    endfunction

endpackage

// File: rtl/video_palette_ram.sv
// 32x6 palette RAM: one CPU write port, registered pixel and CPU read ports.
// Reads are read-before-write, so a same-edge write is seen one cycle later.
module video_palette_ram
    import video_pixel_mux_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       we,
    input  pal_addr_t  cpu_addr,
    input  logic [5:0] wdata,
    input  logic       cpu_re,
    output logic [5:0] cpu_rdata,
    input  logic       pix_re,
    input  pal_addr_t  pix_addr,
    output logic [5:0] pix_rdata
);

    logic [5:0] mem [0:DEPTH-1];
    logic [5:0] cpu_rdata_reg;
    logic [5:0] pix_rdata_reg;

    always_ff @(posedge I_clock) begin
        if (we) begin
            mem[pal_mirror(cpu_addr)] <= wdata;
        end
    end

    // Only the output registers are reset; the array keeps its contents.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            cpu_rdata_reg <= 6'h00;
            pix_rdata_reg <= 6'h00;
        end else begin
            if (cpu_re) begin
                cpu_rdata_reg <= mem[pal_mirror(cpu_addr)];
            end
            if (pix_re) begin
                pix_rdata_reg <= mem[pix_mirror(pix_addr)];
            end
        end
    end

    assign cpu_rdata = cpu_rdata_reg;
    assign pix_rdata = pix_rdata_reg;

endmodule

// File: rtl/video_pixel_mux.sv
// Background/sprite priority, clipping, palette lookup and sprite-0 hit.
// Optional: define VIDEO_PIXEL_EMPHASIS_EN to carry PPUMASK[7:5] alongside O_color.
module video_pixel_mux
    import video_pixel_mux_pkg::*;
#(
    parameter int CLIP_WIDTH  = 8,
    parameter int PAL_ENTRIES = 32
) (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_pixel_valid,
    input  logic [7:0] I_x,
    input  logic [3:0] I_bg_color,
    input  logic [3:0] I_sp_color,
    input  logic       I_sp_priority,
    input  logic       I_sp_zero,
    input  logic [7:0] I_ppumask,
    input  logic       I_clear_flags,
    input  logic       I_pal_we,
    input  logic       I_pal_re,
    input  logic [4:0] I_pal_addr,
    input  logic [5:0] I_pal_wdata,
    output logic [5:0] O_pal_rdata,
    output logic       O_pixel_valid,
    output logic [5:0] O_color,
    output logic [2:0] O_emphasis,
    output logic       O_sprite0_hit
);

    localparam logic [7:0] CLIP_X = 8'(CLIP_WIDTH);

    logic      in_clip;
    logic      bg_op;
    logic      sp_op;
    logic      hit_event;
    pal_addr_t sel_addr_next;

    always_comb begin
        in_clip       = (I_x < CLIP_X);
        bg_op         = (I_bg_color[1:0] != 2'b00) && I_ppumask[PM_BG_EN] &&
                        (!in_clip || I_ppumask[PM_BG_CLIP]);
        sp_op         = (I_sp_color[1:0] != 2'b00) && I_ppumask[PM_SP_EN] &&
                        (!in_clip || I_ppumask[PM_SP_CLIP]);
        hit_event     = I_pixel_valid && bg_op && sp_op && I_sp_zero && (I_x != 8'hFF);
        sel_addr_next = PAL_BACKDROP;
        if (sp_op && (!bg_op || !I_sp_priority)) begin
            sel_addr_next = {1'b1, I_sp_color};
        end else if (bg_op) begin
            sel_addr_next = {1'b0, I_bg_color};
        end
    end

    logic      s1_valid_reg;
    pal_addr_t s1_addr_reg;
    logic      s1_grey_reg;
    logic      s2_valid_reg;
    logic      s2_grey_reg;
    logic      hit_reg;
    logic [5:0] pix_rdata;

    // Payload registers only load on visible pixels so O_color holds between them.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= PAL_BACKDROP;
            s1_grey_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_grey_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= I_pixel_valid;
            s2_valid_reg <= s1_valid_reg;
            if (I_pixel_valid) begin
                s1_addr_reg <= sel_addr_next;
                s1_grey_reg <= I_ppumask[PM_GREYSCALE];
            end
            if (s1_valid_reg) begin
                s2_grey_reg <= s1_grey_reg;
            end
        end
    end

    // Clear has priority over a coincident hit.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            hit_reg <= 1'b0;
        end else if (I_clear_flags) begin
            hit_reg <= 1'b0;
        end else if (hit_event) begin
            hit_reg <= 1'b1;
        end
    end

    video_palette_ram #(
        .DEPTH (PAL_ENTRIES)
    ) u_palette_ram (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .we        (I_pal_we),
        .cpu_addr  (I_pal_addr),
        .wdata     (I_pal_wdata),
        .cpu_re    (I_pal_re),
        .cpu_rdata (O_pal_rdata),
        .pix_re    (s1_valid_reg),
        .pix_addr  (s1_addr_reg),
        .pix_rdata (pix_rdata)
    );

    assign O_pixel_valid = s2_valid_reg;
    assign O_color       = s2_grey_reg ? (pix_rdata & GREY_MASK) : pix_rdata;
    assign O_sprite0_hit = hit_reg;

`ifdef VIDEO_PIXEL_EMPHASIS_EN
    logic [2:0] s1_emph_reg;
    logic [2:0] s2_emph_reg;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            s1_emph_reg <= 3'b000;
            s2_emph_reg <= 3'b000;
        end else begin
            if (I_pixel_valid) begin
                s1_emph_reg <= I_ppumask[PM_EMPH_MSB:PM_EMPH_LSB];
            end
            if (s1_valid_reg) begin
                s2_emph_reg <= s1_emph_reg;
            end
        end
    end

    assign O_emphasis = s2_emph_reg;
`else
    logic unused_emph;
    assign unused_emph = ^I_ppumask[PM_EMPH_MSB:PM_EMPH_LSB];
    assign O_emphasis  = 3'b000;
`endif

endmodule

// File: tb/tb_video_pixel_mux.sv
// Directed bench for video_pixel_mux: behavioural palette/priority model plus literal checks.
module tb_video_pixel_mux;

    logic       clk;
    logic       rst;
    logic       pv;
    logic [7:0] x;
    logic [3:0] bg;
    logic [3:0] sp;
    logic       pri;
    logic       zero;
    logic [7:0] mask;
    logic       clr;
    logic       we;
    logic       re;
    logic [4:0] paddr;
    logic [5:0] wdata;
    logic [5:0] pal_rdata;
    logic       o_valid;
    logic [5:0] o_color;
    logic [2:0] o_emph;
    logic       o_hit;

    int n_tests = 0;
    int n_fail  = 0;

    video_pixel_mux dut (
        .I_clock       (clk),
        .I_reset       (rst),
        .I_pixel_valid (pv),
        .I_x           (x),
        .I_bg_color    (bg),
        .I_sp_color    (sp),
        .I_sp_priority (pri),
        .I_sp_zero     (zero),
        .I_ppumask     (mask),
        .I_clear_flags (clr),
        .I_pal_we      (we),
        .I_pal_re      (re),
        .I_pal_addr    (paddr),
        .I_pal_wdata   (wdata),
        .O_pal_rdata   (pal_rdata),
        .O_pixel_valid (o_valid),
        .O_color       (o_color),
        .O_emphasis    (o_emph),
        .O_sprite0_hit (o_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] pal_m [32];
    logic       exp_v;
    logic [5:0] exp_c;
    logic [2:0] exp_e;
    logic       exp_hit;
    logic [5:0] exp_rd;
    // Pixel requests waiting to emerge, keyed by the edge at which they appear.
    logic       due_v [4];
    logic [4:0] due_a [4];
    logic       due_g [4];
    logic [2:0] due_e [4];
    logic [1:0] slot;

    function automatic logic [4:0] cpu_idx(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic opaque(input logic [1:0] pat, input logic en,
                                    input logic bypass, input logic [7:0] px);
        return (pat != 2'b00) && en && ((px >= 8'd8) || bypass);
    endfunction

    function automatic logic [4:0] pick(input logic [7:0] px, input logic [3:0] b,
                                        input logic [3:0] s, input logic p,
                                        input logic [7:0] m);
        logic bo;
        logic so;
        bo = opaque(b[1:0], m[3], m[1], px);
        so = opaque(s[1:0], m[4], m[2], px);
        if (so && (!bo || !p)) return {1'b1, s};
        if (bo) return {1'b0, b};
        return 5'h00;
    endfunction

    initial begin
        exp_v = 0; exp_c = 0; exp_e = 0; exp_hit = 0; exp_rd = 0; slot = 0;
        for (int i = 0; i < 4; i++) due_v[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_v = 0; exp_c = 0; exp_e = 0; exp_hit = 0; exp_rd = 0; slot = 0;
                for (int i = 0; i < 4; i++) due_v[i] = 0;
            end else begin
                exp_v = due_v[slot];
                if (due_v[slot]) begin
                    exp_c = due_g[slot] ? (pal_m[due_a[slot]] & 6'h30) : pal_m[due_a[slot]];
`ifdef VIDEO_PIXEL_EMPHASIS_EN
                    exp_e = due_e[slot];
`endif
                end
                due_v[slot] = 0;
                if (re) exp_rd = pal_m[cpu_idx(paddr)];
                if (we) pal_m[cpu_idx(paddr)] = wdata;
                if (clr) exp_hit = 0;
                else if (pv && zero && x != 8'd255 &&
                         opaque(bg[1:0], mask[3], mask[1], x) &&
                         opaque(sp[1:0], mask[4], mask[2], x)) exp_hit = 1;
                if (pv) begin
                    due_v[slot + 2'd1] = 1;
                    due_a[slot + 2'd1] = pick(x, bg, sp, pri, mask);
                    due_g[slot + 2'd1] = mask[0];
                    due_e[slot + 2'd1] = mask[7:5];
                end
                slot = slot + 2'd1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_valid", 32'(o_valid), 32'(exp_v));
            chk("mdl_color", 32'(o_color), 32'(exp_c));
            chk("mdl_emph", 32'(o_emph), 32'(exp_e));
            chk("mdl_hit", 32'(o_hit), 32'(exp_hit));
            chk("mdl_rdata", 32'(pal_rdata), 32'(exp_rd));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [5:0] d);
        we = 1; paddr = a; wdata = d;
        tick();
        we = 0;
    endtask

    task automatic rd(input logic [4:0] a);
        re = 1; paddr = a;
        tick();
        re = 0;
    endtask

    task automatic pix(input logic [7:0] px, input logic [3:0] b, input logic [3:0] s,
                       input logic p, input logic z);
        pv = 1; x = px; bg = b; sp = s; pri = p; zero = z;
        tick();
        pv = 0; zero = 0;
    endtask

    logic [7:0] xs [8];
    logic [7:0] ms [4];

    initial begin
        rst = 1; pv = 0; x = 0; bg = 0; sp = 0; pri = 0; zero = 0; mask = 0;
        clr = 0; we = 0; re = 0; paddr = 0; wdata = 0;
        repeat (3) tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_color", 32'(o_color), 0);
        chk("rst_hit", 32'(o_hit), 0);
        chk("rst_rdata", 32'(pal_rdata), 0);
        chk("rst_emph", 32'(o_emph), 0);
        @(posedge clk); #3 rst = 0;
        tick();

        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = 32'(i * 7 + 3);
            wr(v[4:0], v[5:0]);
        end
        wr(5'h00, 6'h3F);
        wr(5'h05, 6'h21);
        wr(5'h11, 6'h16);

        // Background only.
        mask = 8'h1E;
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        tick();
        chk("t1_color", 32'(o_color), 32'h21);
        chk("t1_valid", 32'(o_valid), 1);
        tick();
        chk("t1_idle_valid", 32'(o_valid), 0);
        chk("t1_hold_color", 32'(o_color), 32'h21);

        // Priority.
        pix(8'd20, 4'h5, 4'h1, 0, 0);
        tick();
        chk("t2_sp_front", 32'(o_color), 32'h16);
        pix(8'd20, 4'h5, 4'h1, 1, 0);
        tick();
        chk("t2_sp_behind", 32'(o_color), 32'h21);

        // Clipping and sprite-0 boundaries.
        mask = 8'h18;
        pix(8'd3, 4'h5, 4'h1, 0, 1);
        chk("t3_hit_clip", 32'(o_hit), 0);
        tick();
        chk("t3_color_clip", 32'(o_color), 32'h3F);
        pix(8'd255, 4'h5, 4'h1, 0, 1);
        chk("t3_hit_x255", 32'(o_hit), 0);
        pix(8'd8, 4'h5, 4'h1, 0, 1);
        chk("t3_hit_x8", 32'(o_hit), 1);
        repeat (3) tick();
        chk("t3_hit_sticky", 32'(o_hit), 1);

        // Clear wins over a coincident hit.
        clr = 1;
        pix(8'd8, 4'h5, 4'h1, 0, 1);
        clr = 0;
        chk("t4_clear_wins", 32'(o_hit), 0);
        tick();
        chk("t4_stays_clear", 32'(o_hit), 0);

        // CPU port mirroring, same-address read/write, greyscale.
        wr(5'h10, 6'h2A);
        rd(5'h00);
        chk("t5_rd_mirror00", 32'(pal_rdata), 32'h2A);
        rd(5'h10);
        chk("t5_rd_mirror10", 32'(pal_rdata), 32'h2A);
        mask = 8'h1E;
        pix(8'd20, 4'h0, 4'h0, 0, 0);
        tick();
        chk("t5_backdrop", 32'(o_color), 32'h2A);
        we = 1; re = 1; paddr = 5'h05; wdata = 6'h27;
        tick();
        we = 0; re = 0;
        chk("t5_rw_old", 32'(pal_rdata), 32'h21);
        rd(5'h05);
        chk("t5_rd_new", 32'(pal_rdata), 32'h27);
        mask = 8'h1F;
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        tick();
        chk("t5_grey", 32'(o_color), 32'h20);
        rd(5'h05);
        chk("t5_rd_raw", 32'(pal_rdata), 32'h27);

        // Write on the lookup edge returns old data.
        mask = 8'h1E;
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        wr(5'h05, 6'h0C);
        chk("t5_wr_vs_lookup", 32'(o_color), 32'h27);
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        tick();
        chk("t5_after_wr", 32'(o_color), 32'h0C);

        // Emphasis alignment.
        mask = 8'hFE;
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        mask = 8'h1E;
        tick();
        chk("t6_emph_color", 32'(o_color), 32'h0C);
`ifdef VIDEO_PIXEL_EMPHASIS_EN
        chk("t6_emph", 32'(o_emph), 32'h7);
`else
        chk("t6_emph", 32'(o_emph), 32'h0);
`endif
        pix(8'd20, 4'h5, 4'h0, 0, 0);
        tick();
        chk("t6_emph_off", 32'(o_emph), 32'h0);

        // Back-to-back sweep checked by the model.
        xs[0] = 8'd0;   xs[1] = 8'd7;   xs[2] = 8'd8;   xs[3] = 8'd100;
        xs[4] = 8'd254; xs[5] = 8'd255; xs[6] = 8'd5;   xs[7] = 8'd9;
        ms[0] = 8'h1E;  ms[1] = 8'h18;  ms[2] = 8'hFF;  ms[3] = 8'h0A;
        for (int i = 0; i < 48; i++) begin
            logic [31:0] v;
            v = 32'(i * 37 + 11);
            pv = (i % 5) != 4;
            x = xs[i % 8];
            bg = v[3:0];
            sp = v[7:4];
            pri = v[8];
            zero = v[2];
            mask = ms[(i / 8) % 4];
            clr = (i == 20);
            tick();
        end
        pv = 0; clr = 0; zero = 0;
        repeat (3) tick();

        // Reset in the middle of a stream.
        mask = 8'h18;
        pix(8'd8, 4'h5, 4'h1, 0, 1);
        pv = 1; x = 8'd30; bg = 4'h5; sp = 4'h0;
        tick();
        tick();
        pv = 0;
        @(posedge clk); #2 rst = 1;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 0);
        chk("rst_mid_color", 32'(o_color), 0);
        chk("rst_mid_hit", 32'(o_hit), 0);
        tick();
        @(posedge clk); #3 rst = 0;
        repeat (2) tick();
        chk("rst_mid_after", 32'(o_valid), 0);

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pixel_mux.md
Name: video_pixel_mux

Overview:
- Consumes the 4-bit background colour from the background shifter and the 4-bit sprite pixel from the sprite unit.
- Resolves priority and applies left-column clipping, then looks up the 6-bit master-palette index in an internal 32x6 palette RAM.
- Detects sprite-0 hit and outputs the final pixel colour to the video encoder.
- Hosts the CPU-side palette write/read port.

Parameters:
- CLIP_WIDTH, 8, width in pixels of the left-edge clip region governed by PPUMASK bits 1/2.
- PAL_ENTRIES, 32, palette RAM depth; fixed at 32, present for package consistency only.

Ports:
- I_clock  in  1  pixel clock
- I_reset  in  1  asynchronous active-high reset
- I_pixel_valid  in  1  current cycle carries a visible pixel
- I_x  in  8  screen x of the current pixel (0..255)
- I_bg_color  in  4  {attr[1:0], pattern[1:0]} from the background stage
- I_sp_color  in  4  {sprite palette[1:0], pattern[1:0]}
- I_sp_priority  in  1  1 = sprite behind background
- I_sp_zero  in  1  sprite pixel comes from OAM entry 0
- I_ppumask  in  8  PPUMASK register
- I_clear_flags  in  1  pre-render clear strobe for sprite-0 hit
- I_pal_we  in  1  CPU palette write strobe
- I_pal_re  in  1  CPU palette read strobe
- I_pal_addr  in  5  CPU palette address
- I_pal_wdata  in  6  CPU write data
- O_pal_rdata  out  6  CPU read data
- O_pixel_valid  out  1  O_color is valid
- O_color  out  6  master palette index
- O_emphasis  out  3  colour emphasis bits aligned with O_color
- O_sprite0_hit  out  1  sticky sprite-0 hit flag

Behaviour:
- Reset: all outputs 0, pipeline valid bits 0, sprite-0 flag 0. Palette RAM contents are not reset.
- Pipeline: 2 cycles from I_pixel_valid to O_pixel_valid.
  - S1 registers the resolved 5-bit palette address plus the valid, greyscale and emphasis bits.
  - S2 registers the RAM output.
- Opacity:
  - bg_op = I_bg_color[1:0]!=0 AND I_ppumask[3] AND (I_x>=CLIP_WIDTH OR I_ppumask[1]).
  - sp_op is the same using I_sp_color, I_ppumask[4] and I_ppumask[2].
- Selection:
  - neither opaque -> address 0x00
  - sp only -> {1,sp}
  - bg only -> {0,bg}
  - both -> I_sp_priority ? {0,bg} : {1,sp}
- Mirroring: any address with [1:0]==0 maps to 0x00 on the pixel path. Addresses 0x10/14/18/1C alias 0x00/04/08/0C on CPU writes and reads.
- Greyscale: when I_ppumask[0]=1 at S1, O_color = data & 6'h30.
- Sprite-0 hit:
  - Set when I_pixel_valid, bg_op, sp_op, I_sp_zero and I_x!=255.
  - Sticky until I_clear_flags.
  - Clear and set in the same cycle -> clear wins.
  - Flag update is visible the cycle after the event; it is not pipelined with the colour.
- Invalid pixels: when I_pixel_valid=0 the S1 valid bit is 0 and O_color holds its last value. The sprite-0 flag is not evaluated.
- CPU port:
  - Write takes effect at the clock edge.
  - A pixel lookup of the same entry in the same cycle returns the old data.
  - Read: O_pal_rdata is registered one cycle after I_pal_re and holds otherwise.
  - The read returns raw 6-bit data (no greyscale).
  - Simultaneous we and re to the same address returns old data.
- Reset asserted mid-frame: pipeline flushes immediately; O_pixel_valid=0 from the asserting edge.

Optional Feature:
- VIDEO_PIXEL_EMPHASIS_EN defined: I_ppumask[7:5] is sampled with the pixel at S1 and delayed to align with O_color.
- Not defined: O_emphasis is tied to 3'b000 and no emphasis registers exist.

Decomposition:
- video_control_signals package gains:
  - PPUMASK bit-index constants (greyscale, bg/sp clip, bg/sp enable, emphasis)
  - PAL_BACKDROP = 5'h00
  - a typedef for the 5-bit palette address
  - the mirror function (addr[4] & addr[1:0]==0 -> clear bit 4)
- One sub-module, video_palette_ram:
  - 32x6 RAM
  - one write port and two registered read ports (pixel, CPU)
  - mirroring is applied inside this sub-module

Test Plan:
1. Write 0x3F->pal[0], 0x21->pal[5]. Pixel x=20, bg=4'b0101, sp=0, mask=0x1E -> O_color=0x21 two cycles later, O_pixel_valid=1.
2. Write pal[0x11]=0x16, pal[5]=0x21, mask=0x1E, x=20, bg=0x5, sp=0x1.
   - I_sp_priority=0 -> O_color=0x16.
   - I_sp_priority=1 -> O_color=0x21.
3. Mask=0x18 (no clip bypass), x=3, bg=0x5, sp=0x1, sp_zero=1 -> O_color=pal[0]=0x3F and O_sprite0_hit stays 0.
   - Same pixel at x=8 -> hit=1.
   - Same pixel at x=255 -> no hit.
4. Hit set, then I_clear_flags asserted in the same cycle as a new hit event -> O_sprite0_hit=0.
5. Write 0x2A to 0x10, CPU read 0x00 -> O_pal_rdata=0x2A. Greyscale mask bit0=1 with pal[5]=0x27 -> O_color=0x20.
6. Emphasis build: mask=0xFE -> O_emphasis=3'b111 aligned with O_color. Non-emphasis build -> 0. Reset mid-stream -> O_pixel_valid=0, O_color=0, hit=0.
